ray_lane_scheduler: RTL
=======================

Name: ray_lane_scheduler

Overview:
- Multi-lane successor to the single-pipe ray tracing unit.
- Dispatches pixel indices of one frame across NUM_LANES parallel ray generator/processor lanes, statically interleaved.
- Collects lane colour results back in raster order and emits one pixel stream with sof/last_x framing under ready_external back-pressure.
- Sits between the camera/config registers and the video output; lanes and their ROM ports sit outside this block.

Parameters:
- NUM_LANES, 4, number of parallel ray lanes (1..16).
- DIM_W, 13, width of image_width/image_height.
- IDX_W, 32, width of pixel index (loop_index) sent to lanes.
- COLOR_W, 8, width of each colour channel.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- image_width  in  DIM_W  pixels per line; sampled on frame_start.
- image_height  in  DIM_W  lines per frame; sampled on frame_start.
- frame_start  in  1  one-cycle pulse that starts a frame.
- busy  out  1  high from accepted frame_start until the last pixel handshake.
- frame_done  out  1  one-cycle pulse on the last pixel handshake.
- lane_req_valid  out  NUM_LANES  per-lane request valid.
- lane_req_index  out  NUM_LANES*IDX_W  per-lane pixel index; lane k occupies slice k.
- lane_req_ready  in  NUM_LANES  per-lane request ready.
- lane_rsp_valid  in  NUM_LANES  per-lane result valid.
- lane_rsp_rgb  in  NUM_LANES*3*COLOR_W  per-lane {r,g,b}; r in the MSBs.
- lane_rsp_ready  out  NUM_LANES  per-lane result accept.
- ready_external  in  1  downstream ready.
- valid_data_out  out  1  output pixel valid.
- r, g, b  out  COLOR_W each  output colour.
- sof  out  1  high with pixel index 0.
- last_x  out  1  high with the last pixel of each line.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE: busy=0. frame_start with W!=0 and H!=0 latches W, H and total=W*H (2*DIM_W bits), then goes to RUN. frame_start with W=0 or H=0 is ignored.
  - RUN: dispatch and collect concurrently. Move to DRAIN when dispatch_idx reaches total.
  - DRAIN: collect only. Return to IDLE on the handshake of pixel total-1, pulsing frame_done in that cycle.
- frame_start while busy is ignored.
- Dispatch:
  - Pixel i goes only to lane i mod NUM_LANES.
  - One dispatch pointer: lane_req_valid is one-hot on lane (dispatch_idx mod NUM_LANES), with lane_req_index = dispatch_idx.
  - Pointer advances on valid&ready.
  - The valid/index of a pending request are held stable until ready.
  - No request is issued at index >= total.
  - Each lane may hold up to 2 issued-but-uncollected pixels. Dispatch stalls when the target lane's outstanding count is 2.
- Collect:
  - Collect pointer c; only lane (c mod NUM_LANES) sees lane_rsp_ready=1, and only when the output register is empty or being drained this cycle.
  - Responses from other lanes wait, held by the lane. Cross-lane response order therefore does not affect output order.
  - Lanes return their own results in request order.
- Output register:
  - Loaded on the collect handshake; valid_data_out rises the next cycle (1-cycle latency from lane_rsp handshake).
  - Data and flags are stable while valid_data_out=1 and ready_external=0.
  - Back-to-back pixels are allowed when ready_external=1 (full throughput, one pixel/clk).
- Framing:
  - sof=1 only on output pixel 0.
  - Line counter x wraps at W-1; last_x=1 when x==W-1.
  - For W=1 every pixel has last_x=1.
- Wrap-around:
  - Dispatch and collect lane pointers wrap at NUM_LANES-1.
  - Index counters are IDX_W wide. Total never exceeds (2^DIM_W-1)^2, so they do not overflow.
- total not a multiple of NUM_LANES: trailing lanes receive no request. The collect pointer still follows index order, so no stall results.
- Simultaneous events: frame_done and a new frame_start in the same cycle — frame_start is ignored (state is not yet IDLE).
- Reset mid-frame: asynchronous clear of all state. In-flight lane results are dropped; lanes are reset by the same reset_n.

Test Plan:
- NUM_LANES=4, W=4, H=2, lanes echo index as r, 1-cycle latency, ready_external=1 -> 8 pixels r=0..7 on consecutive cycles; sof on r=0; last_x on r=3 and r=7; frame_done with r=7.
- Same frame, lane 2 responds 5 cycles before lane 0 -> output order still r=0,1,2,...; lane 2 lane_rsp_ready stays 0 until pixel 1 is collected.
- ready_external toggled 1,0,0,1 repeatedly -> no pixel lost or duplicated; r/g/b/sof/last_x stable while stalled.
- W=3, H=1, NUM_LANES=4 -> lane 3 never requested; 3 pixels out; last_x on pixel 2; busy falls after pixel 2.
- frame_start during RUN, and frame_start with W=0 in IDLE -> both ignored; busy and index sequences unaffected.
- reset_n low at pixel 5 of a 16-pixel frame -> all outputs 0 asynchronously; a new frame_start then produces a clean frame with sof on index 0.

Source files
------------

// File: rtl/ray_lane_scheduler.sv
// Multi-lane ray scheduler: interleaves pixel indices of one frame across
// NUM_LANES lanes, then gathers lane colours back in raster order into a
// single framed pixel stream with downstream back-pressure.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for frame_start with nonzero width and height
// RUN   | dispatching pixel indices to lanes while collecting results
// DRAIN | every index issued; collecting and emitting remaining pixels
module ray_lane_scheduler #(
   parameter int NUM_LANES = 4,
   parameter int DIM_W     = 13,
   parameter int IDX_W     = 32,
   parameter int COLOR_W   = 8
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [DIM_W-1:0]                 image_width,
   input  logic [DIM_W-1:0]                 image_height,
   input  logic                             frame_start,
   output logic                             busy,
   output logic                             frame_done,
   output logic [NUM_LANES-1:0]             lane_req_valid,
   output logic [NUM_LANES*IDX_W-1:0]       lane_req_index,
   input  logic [NUM_LANES-1:0]             lane_req_ready,
   input  logic [NUM_LANES-1:0]             lane_rsp_valid,
   input  logic [NUM_LANES*3*COLOR_W-1:0]   lane_rsp_rgb,
   output logic [NUM_LANES-1:0]             lane_rsp_ready,
   input  logic                             ready_external,
   output logic                             valid_data_out,
   output logic [COLOR_W-1:0]               r,
   output logic [COLOR_W-1:0]               g,
   output logic [COLOR_W-1:0]               b,
   output logic                             sof,
   output logic                             last_x
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int TOT_W  = 2 * DIM_W;
   localparam int RGB_W  = 3 * COLOR_W;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t             state, state_nxt;
   logic [DIM_W-1:0]   width_q;
   logic [IDX_W-1:0]   total_q;
   logic [IDX_W-1:0]   disp_idx, coll_idx;
   logic [LANE_W-1:0]  disp_lane, coll_lane;
   logic [DIM_W-1:0]   x_q;
   logic [1:0]         outst [NUM_LANES];

   logic               out_valid, out_sof, out_last_x, out_last;
   logic [RGB_W-1:0]   out_rgb;

   logic               frame_go, active, disp_ok, req_fire;
   logic               out_free, out_fire, coll_ok, coll_fire;
   logic [RGB_W-1:0]   rsp_sel;
   logic [NUM_LANES-1:0] req_hit, rsp_hit;

   assign frame_go  = (state == S_IDLE) && frame_start &&
                      (image_width != '0) && (image_height != '0);
   assign active    = (state != S_IDLE);
   // A lane already holding two uncollected pixels blocks the single pointer.
   assign disp_ok   = (state == S_RUN) && (disp_idx < total_q) && (outst[disp_lane] != 2'd2);
   assign req_fire  = disp_ok && lane_req_ready[disp_lane];
   assign out_fire  = out_valid && ready_external;
   assign out_free  = !out_valid || ready_external;
   assign coll_ok   = active && (coll_idx < total_q) && out_free;
   assign coll_fire = coll_ok && lane_rsp_valid[coll_lane];
   assign rsp_sel   = lane_rsp_rgb[int'(coll_lane)*RGB_W +: RGB_W];
   assign req_hit   = lane_req_valid & lane_req_ready;
   assign rsp_hit   = lane_rsp_ready & lane_rsp_valid;

   // Every slice carries the pointer; only the one-hot valid selects a lane.
   assign lane_req_index = {NUM_LANES{disp_idx}};
   assign busy           = active;
   assign frame_done     = out_fire && out_last;
   assign valid_data_out = out_valid;
   assign r              = out_rgb[3*COLOR_W-1 -: COLOR_W];
   assign g              = out_rgb[2*COLOR_W-1 -: COLOR_W];
   assign b              = out_rgb[COLOR_W-1:0];
   assign sof            = out_sof;
   assign last_x         = out_last_x;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next state and one-hot lane handshake strobes.
   always_comb begin
      state_nxt      = state;
      lane_req_valid = '0;
      lane_rsp_ready = '0;
      lane_req_valid[disp_lane] = disp_ok;
      lane_rsp_ready[coll_lane] = coll_ok;
      unique case (state)
         S_IDLE:  if (frame_go) state_nxt = S_RUN;
         S_RUN: begin
            if (out_fire && out_last)   state_nxt = S_IDLE;
            else if (disp_idx == total_q) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (out_fire && out_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame geometry, dispatch/collect pointers and line position.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         width_q   <= '0;
         total_q   <= '0;
         disp_idx  <= '0;
         coll_idx  <= '0;
         disp_lane <= '0;
         coll_lane <= '0;
         x_q       <= '0;
      end else if (frame_go) begin
         width_q   <= image_width;
         total_q   <= IDX_W'(TOT_W'(image_width) * TOT_W'(image_height));
         disp_idx  <= '0;
         coll_idx  <= '0;
         disp_lane <= '0;
         coll_lane <= '0;
         x_q       <= '0;
      end else begin
         if (req_fire) begin
            disp_idx  <= disp_idx + IDX_W'(1);
            disp_lane <= (disp_lane == LAST_LANE) ? '0 : disp_lane + LANE_W'(1);
         end
         if (coll_fire) begin
            coll_idx  <= coll_idx + IDX_W'(1);
            coll_lane <= (coll_lane == LAST_LANE) ? '0 : coll_lane + LANE_W'(1);
            x_q       <= (x_q == width_q - DIM_W'(1)) ? '0 : x_q + DIM_W'(1);
         end
      end
   end

   // Per-lane issued-but-uncollected count; same-cycle issue and collect cancel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_LANES; k++) outst[k] <= 2'd0;
      end else begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (req_hit[k] && !rsp_hit[k])      outst[k] <= outst[k] + 2'd1;
            else if (!req_hit[k] && rsp_hit[k]) outst[k] <= outst[k] - 2'd1;
         end
      end
   end

   // Output register: loaded on collect, held until the downstream accepts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_rgb    <= '0;
         out_sof    <= 1'b0;
         out_last_x <= 1'b0;
         out_last   <= 1'b0;
      end else if (coll_fire) begin
         out_valid  <= 1'b1;
         out_rgb    <= rsp_sel;
         out_sof    <= (coll_idx == '0);
         out_last_x <= (x_q == width_q - DIM_W'(1));
         out_last   <= (coll_idx == total_q - IDX_W'(1));
      end else if (out_fire) begin
         out_valid  <= 1'b0;
      end
   end

endmodule
